// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: a fetch pointer that reads an asynchronous
// instruction memory, plus a 2-entry {instruction, pc} buffer towards decode.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | one cycle after reset release; no fetch, redirects ignored
// FETCH   | issue one fetch per cycle whenever the buffer has room
// HALTED  | no new fetches; buffer keeps draining; redirects still apply
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter int          DATA_W   = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [1:0]        count_q, count_d;

  // Entry 0 is always the head; entry 1 is the tail when two are buffered.
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [ADDR_W-1:0] pc0_q, pc1_q;

  logic       pop;
  logic       flush;
  logic       fetch;
  logic [1:0] wr_slot;

  assign mem_addr   = fpc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = data0_q;
  assign inst_pc    = pc0_q;
  assign state      = state_q;

  // Per-cycle actions: redirect outranks pop and fetch outside IDLE.
  always_comb begin
    pop     = inst_valid && inst_ready;
    flush   = redirect_valid && (state_q != S_IDLE);
    fetch   = (state_q == S_FETCH) && !redirect_valid && !halt &&
              ((count_q != 2'd2) || pop);
    // Tail slot after this cycle's pop has shifted the buffer.
    wr_slot = count_q - {1'b0, pop};
    fpc_d   = fpc_q;
    count_d = count_q;
    if (flush) begin
      fpc_d   = redirect_pc;
      count_d = 2'd0;
    end else begin
      if (fetch) begin
        fpc_d = fpc_q + ADDR_W'(1);
      end
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  // Control state: FSM, fetch pointer and occupancy, all cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fpc_q   <= ADDR_W'(RESET_PC);
      count_q <= 2'd0;
    end else begin
      fpc_q   <= fpc_d;
      count_q <= count_d;
      case (state_q)
        S_IDLE:   state_q <= S_FETCH;
        S_FETCH:  if (halt)  state_q <= S_HALTED;
        S_HALTED: if (!halt) state_q <= S_FETCH;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Buffer payload: shift on pop, then write the fetched word into the tail.
  // Contents are qualified by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (pop) begin
      data0_q <= data1_q;
      pc0_q   <= pc1_q;
    end
    if (fetch) begin
      if (wr_slot[0]) begin
        data1_q <= mem_rdata;
        pc1_q   <= fpc_q;
      end else begin
        data0_q <= mem_rdata;
        pc0_q   <= fpc_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl against a 64-word memory holding
// 0x1000_0000 + k at word k.
module tb_imem_fetch_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic [1:0]        state;

  logic [DATA_W-1:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .state          (state)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    step();
    step();
    check_eq("rst_state",    state,      0);
    check_eq("rst_valid",    inst_valid, 0);
    check_eq("rst_mem_addr", mem_addr,   0);

    // Free-running stream from reset.
    rst = 1'b0;
    step();
    check_eq("idle_to_fetch", state,      1);
    check_eq("valid_edge1",   inst_valid, 0);
    step();
    check_eq("valid_edge2",   inst_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("stream_pc%0d", i),   inst_pc,   i);
      check_eq($sformatf("stream_data%0d", i), inst_data, 32'h1000_0000 + i);
      step();
    end

    // Asynchronous reset mid-stream, with a redirect pending across release.
    #3;
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 6'd20;
    inst_ready     = 1'b0;
    #2;
    check_eq("async_rst_valid", inst_valid, 0);
    check_eq("async_rst_addr",  mem_addr,   0);
    check_eq("async_rst_state", state,      0);
    step();
    rst = 1'b0;
    step();
    check_eq("idle_redirect_ignored", mem_addr, 0);
    check_eq("idle_redirect_state",   state,    1);
    redirect_valid = 1'b0;
    step();
    step();
    step();
    step();

    // Stalled decode: buffer saturates with pcs 0,1 and fpc stops at 2.
    check_eq("stall_valid", inst_valid, 1);
    check_eq("stall_pc",    inst_pc,    0);
    check_eq("stall_data",  inst_data,  32'h1000_0000);
    check_eq("stall_addr",  mem_addr,   2);
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq($sformatf("drain_pc%0d", i),   inst_pc,   i);
      check_eq($sformatf("drain_data%0d", i), inst_data, 32'h1000_0000 + i);
    end

    // Redirect with two entries buffered and a pop in the same cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd40;
    step();
    check_eq("redir_flush_valid", inst_valid, 0);
    check_eq("redir_addr",        mem_addr,   40);
    redirect_valid = 1'b0;
    step();
    check_eq("redir_pc",   inst_pc,   40);
    check_eq("redir_data", inst_data, 32'h1000_0028);

    // Address wrap 62,63,0,1.
    redirect_valid = 1'b1;
    redirect_pc    = 6'd61;
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("wrap_pc61", inst_pc, 61);
    step();
    check_eq("wrap_pc62", inst_pc, 62);
    step();
    check_eq("wrap_pc63",  inst_pc,  63);
    check_eq("wrap_addr0", mem_addr, 0);
    step();
    check_eq("wrap_pc0",   inst_pc,   0);
    check_eq("wrap_data0", inst_data, 32'h1000_0000);
    step();
    check_eq("wrap_pc1", inst_pc, 1);

    // Halt with two entries buffered: drain, hold fpc, then resume.
    inst_ready = 1'b0;
    step();
    halt = 1'b1;
    step();
    check_eq("halt_state",   state,    2);
    check_eq("halt_addr",    mem_addr, 3);
    check_eq("halt_head_pc", inst_pc,  1);
    inst_ready = 1'b1;
    step();
    check_eq("halt_pop_pc", inst_pc, 2);
    step();
    check_eq("halt_empty", inst_valid, 0);
    check_eq("halt_hold",  mem_addr,   3);
    halt = 1'b0;
    step();
    check_eq("resume_state", state,      1);
    check_eq("resume_valid", inst_valid, 0);
    step();
    check_eq("resume_pc",   inst_pc,   3);
    check_eq("resume_data", inst_data, 32'h1000_0003);

    // Redirect while halted keeps HALTED but moves fpc and flushes.
    halt = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 6'd10;
    step();
    check_eq("hredir_state", state,      2);
    check_eq("hredir_addr",  mem_addr,   10);
    check_eq("hredir_valid", inst_valid, 0);
    redirect_valid = 1'b0;
    halt           = 1'b0;
    step();
    step();
    check_eq("hredir_pc",   inst_pc,   10);
    check_eq("hredir_data", inst_data, 32'h1000_000A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
